// File: rtl/stg_mo_if.sv
// -----------------------------------------------------------------------------
// stg_mo_if : data-memory port of the memory-operation stage (stg_mo).
//
// Carries one req/ack transaction at a time. The stage (master) raises
// ow_mem_req with direction/address/write data held stable until the memory
// (slave) returns iw_mem_ack; read data is valid in the ack cycle.
//
// Signals
//   ow_mem_req    stage -> mem   request pending
//   ow_mem_we     stage -> mem   1 = write, 0 = read
//   ow_mem_addr   stage -> mem   ADDR_W address
//   ow_mem_wdata  stage -> mem   DATA_W write data
//   iw_mem_ack    mem -> stage   completion, rdata valid this cycle
//   iw_mem_rdata  mem -> stage   DATA_W read data
// -----------------------------------------------------------------------------
interface stg_mo_if #(
   parameter int ADDR_W = 48,
   parameter int DATA_W = 24
);
   logic              ow_mem_req;
   logic              ow_mem_we;
   logic [ADDR_W-1:0] ow_mem_addr;
   logic [DATA_W-1:0] ow_mem_wdata;
   logic              iw_mem_ack;
   logic [DATA_W-1:0] iw_mem_rdata;

   modport master (
      output ow_mem_req,
      output ow_mem_we,
      output ow_mem_addr,
      output ow_mem_wdata,
      input  iw_mem_ack,
      input  iw_mem_rdata
   );

   modport slave (
      input  ow_mem_req,
      input  ow_mem_we,
      input  ow_mem_addr,
      input  ow_mem_wdata,
      output iw_mem_ack,
      output iw_mem_rdata
   );
endinterface

// File: rtl/stg_mo.sv
// -----------------------------------------------------------------------------
// stg_mo : pipeline stage 5, memory operation (feeds writeback).
//
// ALU ops pass through one register stage. Loads/stores are latched, issued on
// the data-memory port (stg_mo_if, master side) and the stage stalls upstream
// until the memory acks; the completed op is then presented to writeback.
//
// Optional feature: define MO_TIMEOUT_EN to enable a BUSY timeout counter
// (TIMEOUT_CYC cycles) that aborts the access and pulses ow_fault. Without the
// macro BUSY waits indefinitely and ow_fault is tied low.
//
// Ports
//   iw_clk, iw_rst        clock, asynchronous active-high reset
//   iw_valid .. iw_result op from stage 4 (pc, instr, opc, load/store flags,
//                         memory address, store data, GP target, ALU result)
//   ow_stall              upstream must hold its inputs (state BUSY)
//   mem                   data-memory req/ack port
//   ow_valid .. ow_result op presented to writeback (registered)
//   ow_fault              one-cycle memory timeout abort flag
// -----------------------------------------------------------------------------
module stg_mo #(
   parameter int DATA_W   = 24,
   parameter int ADDR_W   = 48,
   parameter int TGT_GP_W = 4,
   parameter int OPC_W    = 8
`ifdef MO_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic                iw_clk,
   input  logic                iw_rst,
   input  logic                iw_valid,
   input  logic [ADDR_W-1:0]   iw_pc,
   input  logic [DATA_W-1:0]   iw_instr,
   input  logic [OPC_W-1:0]    iw_opc,
   input  logic                iw_is_load,
   input  logic                iw_is_store,
   input  logic [ADDR_W-1:0]   iw_mem_addr,
   input  logic [DATA_W-1:0]   iw_store_data,
   input  logic [TGT_GP_W-1:0] iw_tgt_gp,
   input  logic                iw_tgt_gp_we,
   input  logic [DATA_W-1:0]   iw_result,
   output logic                ow_stall,
   stg_mo_if.master            mem,
   output logic                ow_valid,
   output logic [ADDR_W-1:0]   ow_pc,
   output logic [DATA_W-1:0]   ow_instr,
   output logic [OPC_W-1:0]    ow_opc,
   output logic [TGT_GP_W-1:0] ow_tgt_gp,
   output logic                ow_tgt_gp_we,
   output logic [DATA_W-1:0]   ow_result,
   output logic                ow_fault
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t state_r, state_s;

   // memory port registers
   logic              req_r,       req_s;
   logic              mem_we_r,    mem_we_s;
   logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

   // op latched while its memory access is outstanding
   logic [ADDR_W-1:0]   lat_pc_r,        lat_pc_s;
   logic [DATA_W-1:0]   lat_instr_r,     lat_instr_s;
   logic [OPC_W-1:0]    lat_opc_r,       lat_opc_s;
   logic                lat_is_load_r,   lat_is_load_s;
   logic [TGT_GP_W-1:0] lat_tgt_gp_r,    lat_tgt_gp_s;
   logic                lat_tgt_gp_we_r, lat_tgt_gp_we_s;
   logic [DATA_W-1:0]   lat_result_r,    lat_result_s;

   // writeback output registers
   logic                wb_valid_r,     wb_valid_s;
   logic [ADDR_W-1:0]   wb_pc_r,        wb_pc_s;
   logic [DATA_W-1:0]   wb_instr_r,     wb_instr_s;
   logic [OPC_W-1:0]    wb_opc_r,       wb_opc_s;
   logic [TGT_GP_W-1:0] wb_tgt_gp_r,    wb_tgt_gp_s;
   logic                wb_tgt_gp_we_r, wb_tgt_gp_we_s;
   logic [DATA_W-1:0]   wb_result_r,    wb_result_s;

   logic mem_ack_s;

`ifdef MO_TIMEOUT_EN
   // Abort fires on the BUSY cycle that brings the count up to TIMEOUT_CYC.
   localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT_CYC - 1);

   logic [7:0] to_cnt_r, to_cnt_s;
   logic       fault_r,  fault_s;
`endif

   // An ack only counts while a request is actually outstanding.
   assign mem_ack_s = mem.iw_mem_ack & req_r;

   // Next-state, memory-port and writeback next values.
   always_comb begin
      state_s         = state_r;
      req_s           = req_r;
      mem_we_s        = mem_we_r;
      mem_addr_s      = mem_addr_r;
      mem_wdata_s     = mem_wdata_r;
      lat_pc_s        = lat_pc_r;
      lat_instr_s     = lat_instr_r;
      lat_opc_s       = lat_opc_r;
      lat_is_load_s   = lat_is_load_r;
      lat_tgt_gp_s    = lat_tgt_gp_r;
      lat_tgt_gp_we_s = lat_tgt_gp_we_r;
      lat_result_s    = lat_result_r;
      // bubble by default: valid/we drop, the rest of WB holds
      wb_valid_s      = 1'b0;
      wb_pc_s         = wb_pc_r;
      wb_instr_s      = wb_instr_r;
      wb_opc_s        = wb_opc_r;
      wb_tgt_gp_s     = wb_tgt_gp_r;
      wb_tgt_gp_we_s  = 1'b0;
      wb_result_s     = wb_result_r;
`ifdef MO_TIMEOUT_EN
      to_cnt_s        = to_cnt_r;
      fault_s         = 1'b0;
`endif

      case (state_r)
         ST_IDLE: begin
            if (iw_valid && (iw_is_load || iw_is_store)) begin
               // load wins when both flags are set
               lat_pc_s        = iw_pc;
               lat_instr_s     = iw_instr;
               lat_opc_s       = iw_opc;
               lat_is_load_s   = iw_is_load;
               lat_tgt_gp_s    = iw_tgt_gp;
               lat_tgt_gp_we_s = iw_tgt_gp_we;
               lat_result_s    = iw_result;
               req_s           = 1'b1;
               mem_we_s        = iw_is_store & ~iw_is_load;
               mem_addr_s      = iw_mem_addr;
               mem_wdata_s     = iw_store_data;
               state_s         = ST_BUSY;
`ifdef MO_TIMEOUT_EN
               to_cnt_s        = 8'd0;
`endif
            end else if (iw_valid) begin
               wb_valid_s     = 1'b1;
               wb_pc_s        = iw_pc;
               wb_instr_s     = iw_instr;
               wb_opc_s       = iw_opc;
               wb_tgt_gp_s    = iw_tgt_gp;
               wb_tgt_gp_we_s = iw_tgt_gp_we;
               wb_result_s    = iw_result;
            end else begin
               wb_valid_s = 1'b0;
            end
         end

         ST_BUSY: begin
            if (mem_ack_s) begin
               req_s          = 1'b0;
               state_s        = ST_IDLE;
               wb_valid_s     = 1'b1;
               wb_pc_s        = lat_pc_r;
               wb_instr_s     = lat_instr_r;
               wb_opc_s       = lat_opc_r;
               wb_tgt_gp_s    = lat_tgt_gp_r;
               wb_tgt_gp_we_s = lat_tgt_gp_we_r & lat_is_load_r;
               wb_result_s    = lat_is_load_r ? mem.iw_mem_rdata : lat_result_r;
            end else begin
`ifdef MO_TIMEOUT_EN
               if (to_cnt_r == TO_LAST_C) begin
                  // give up: present the op without a GP write and flag it
                  req_s          = 1'b0;
                  state_s        = ST_IDLE;
                  to_cnt_s       = to_cnt_r + 8'd1;
                  fault_s        = 1'b1;
                  wb_valid_s     = 1'b1;
                  wb_pc_s        = lat_pc_r;
                  wb_instr_s     = lat_instr_r;
                  wb_opc_s       = lat_opc_r;
                  wb_tgt_gp_s    = lat_tgt_gp_r;
                  wb_tgt_gp_we_s = 1'b0;
                  wb_result_s    = lat_result_r;
               end else begin
                  to_cnt_s = to_cnt_r + 8'd1;
               end
`else
               state_s = ST_BUSY;
`endif
            end
         end

         default: begin
            state_s = ST_IDLE;
            req_s   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset drops any outstanding request at once.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_r         <= ST_IDLE;
         req_r           <= 1'b0;
         mem_we_r        <= 1'b0;
         mem_addr_r      <= {ADDR_W{1'b0}};
         mem_wdata_r     <= {DATA_W{1'b0}};
         lat_pc_r        <= {ADDR_W{1'b0}};
         lat_instr_r     <= {DATA_W{1'b0}};
         lat_opc_r       <= {OPC_W{1'b0}};
         lat_is_load_r   <= 1'b0;
         lat_tgt_gp_r    <= {TGT_GP_W{1'b0}};
         lat_tgt_gp_we_r <= 1'b0;
         lat_result_r    <= {DATA_W{1'b0}};
         wb_valid_r      <= 1'b0;
         wb_pc_r         <= {ADDR_W{1'b0}};
         wb_instr_r      <= {DATA_W{1'b0}};
         wb_opc_r        <= {OPC_W{1'b0}};
         wb_tgt_gp_r     <= {TGT_GP_W{1'b0}};
         wb_tgt_gp_we_r  <= 1'b0;
         wb_result_r     <= {DATA_W{1'b0}};
      end else begin
         state_r         <= state_s;
         req_r           <= req_s;
         mem_we_r        <= mem_we_s;
         mem_addr_r      <= mem_addr_s;
         mem_wdata_r     <= mem_wdata_s;
         lat_pc_r        <= lat_pc_s;
         lat_instr_r     <= lat_instr_s;
         lat_opc_r       <= lat_opc_s;
         lat_is_load_r   <= lat_is_load_s;
         lat_tgt_gp_r    <= lat_tgt_gp_s;
         lat_tgt_gp_we_r <= lat_tgt_gp_we_s;
         lat_result_r    <= lat_result_s;
         wb_valid_r      <= wb_valid_s;
         wb_pc_r         <= wb_pc_s;
         wb_instr_r      <= wb_instr_s;
         wb_opc_r        <= wb_opc_s;
         wb_tgt_gp_r     <= wb_tgt_gp_s;
         wb_tgt_gp_we_r  <= wb_tgt_gp_we_s;
         wb_result_r     <= wb_result_s;
      end
   end

`ifdef MO_TIMEOUT_EN
   // Timeout counter and one-cycle fault flag.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         to_cnt_r <= 8'd0;
         fault_r  <= 1'b0;
      end else begin
         to_cnt_r <= to_cnt_s;
         fault_r  <= fault_s;
      end
   end

   assign ow_fault = fault_r;
`else
   assign ow_fault = 1'b0;
`endif

   assign ow_stall         = (state_r == ST_BUSY);
   assign mem.ow_mem_req   = req_r;
   assign mem.ow_mem_we    = mem_we_r;
   assign mem.ow_mem_addr  = mem_addr_r;
   assign mem.ow_mem_wdata = mem_wdata_r;
   assign ow_valid         = wb_valid_r;
   assign ow_pc            = wb_pc_r;
   assign ow_instr         = wb_instr_r;
   assign ow_opc           = wb_opc_r;
   assign ow_tgt_gp        = wb_tgt_gp_r;
   assign ow_tgt_gp_we     = wb_tgt_gp_we_r;
   assign ow_result        = wb_result_r;

endmodule
